// File: rtl/inst_sram_pkg.sv
// Shared definitions for the instruction-SRAM responder: FSM state encoding,
// default boot-region base address, the exception vector shared with the core,
// and a per-byte parity helper.
package inst_sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR        = 32'hbfc0_0380;

  // Even parity per byte: the stored bit makes each 9-bit group have even weight.
  function automatic logic [3:0] byte_parity(input logic [31:0] w);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) begin
      p[b] = ^w[8*b +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/inst_sram_array.sv
// Single-port word storage with four byte write enables. Writes commit on the
// clock edge; the read port is combinational so the responder's output register
// gives the one-cycle read latency and a write is visible to the very next read.
// With INST_SRAM_PARITY_EN defined, one parity bit per byte is stored and
// written under the same byte enable.
module inst_sram_array
  import inst_sram_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
`ifdef INST_SRAM_PARITY_EN
  ,
  output logic [3:0]        rpar_o
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // Byte-lane writes into the data array.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem[idx_i];

`ifdef INST_SRAM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] wpar;

  assign wpar = byte_parity(wdata_i);

  // Parity lanes follow their byte enables.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) par_mem[idx_i][b] <= wpar[b];
    end
  end

  assign rpar_o = par_mem[idx_i];
`endif

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder. Decodes fetch requests against the boot window,
// serves reads with one-cycle latency, and holds rdata/addr_err while en is low
// so a stalled fetch keeps its instruction. After reset an INIT sweep zeroes the
// array one word per cycle (when CLEAR_ON_RESET=1); requests are ignored until
// init_done. Optional macro INST_SRAM_PARITY_EN adds per-byte parity storage and
// the registered parity_err output.
//
// Handshake: a request is a single-cycle pulse of inst_sram_en; there is no
// ready/backpressure. It is accepted on the edge where en=1 and state is READY;
// read data for it is valid right after that edge and holds until the next
// accepted read.
module inst_sram_resp
  import inst_sram_pkg::*;
#(
  parameter int          ADDR_W         = 14,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        addr_err,
  output logic        init_done,
`ifdef INST_SRAM_PARITY_EN
  output logic        parity_err,
`endif
  output state_e      state_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              addr_err_q, addr_err_d;

  logic              hit;
  logic [ADDR_W-1:0] req_idx;
  logic              accept;
  logic              is_read;

  logic [3:0]        arr_we;
  logic [ADDR_W-1:0] arr_idx;
  logic [31:0]       arr_wdata;
  logic [31:0]       arr_rdata;

  // Byte offset bits are the fetch stage's concern, not ours.
  logic unused_addr_lo;
  assign unused_addr_lo = ^inst_sram_addr[1:0];

  assign hit     = inst_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign req_idx = inst_sram_addr[ADDR_W+1:2];
  assign accept  = (state_q == READY) && inst_sram_en;
  assign is_read = inst_sram_wen == 4'b0000;

  // FSM next state, sweep counter and array port steering.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 4'b0000;
    arr_idx   = req_idx;
    arr_wdata = inst_sram_wdata;
    case (state_q)
      INIT: begin
        arr_we    = 4'b1111;
        arr_idx   = cnt_q;
        arr_wdata = 32'h0;
        cnt_d     = cnt_q + ONE_IDX;
        if (cnt_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        if (inst_sram_en && hit) arr_we = inst_sram_wen;
      end
      default: state_d = INIT;
    endcase
  end

  // Output register next values: only an accepted request changes them.
  always_comb begin
    rdata_d    = rdata_q;
    addr_err_d = addr_err_q;
    if (accept) begin
      addr_err_d = !hit;
      if (is_read) rdata_d = hit ? arr_rdata : 32'h0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? INIT : READY;
      cnt_q      <= '0;
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef INST_SRAM_PARITY_EN
  logic [3:0] arr_rpar;
  logic       perr_q, perr_d;

  // Parity check is only meaningful on an in-range read; anything else clears it.
  always_comb begin
    perr_d = perr_q;
    if (accept) perr_d = hit && is_read && (|(arr_rpar ^ byte_parity(arr_rdata)));
  end

  // Parity error register, aligned with rdata.
  always_ff @(posedge clk) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`endif

  inst_sram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .idx_i   (arr_idx),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
`ifdef INST_SRAM_PARITY_EN
    ,
    .rpar_o  (arr_rpar)
`endif
  );

  assign inst_sram_rdata = rdata_q;
  assign addr_err        = addr_err_q;
  assign init_done       = state_q == READY;
  assign state_o         = state_q;

endmodule

// File: doc/inst_sram_resp.md
# inst_sram_resp

Responder end of the instruction-SRAM interface driven by the fetch stage: accepts en/wen/addr/wdata requests and returns rdata with fixed one-cycle latency, holding rdata stable while en is low so a stalled fetch stage keeps seeing its instruction. Backs a word-addressed on-chip array mapped at the boot region, clears it after reset via an init sweep, and flags out-of-range accesses. Sits between the CPU core's inst_sram port and the SoC; the SoC holds the CPU in reset until init_done.

## Interface
- ADDR_W, 14, word-index width; array holds 2^ADDR_W 32-bit words (64 KB default).
- BASE_ADDR, 32'hbfc0_0000, byte base of the mapped window; must be aligned to 2^(ADDR_W+2).
- CLEAR_ON_RESET, 1, 1 = run zeroing sweep after reset; 0 = ready immediately, contents undefined.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- inst_sram_en  in  1  request valid this cycle.
- inst_sram_wen  in  4  byte write enables; 0 = read.
- inst_sram_addr  in  32  byte address.
- inst_sram_wdata  in  32  write data.
- inst_sram_rdata  out  32  read data, registered.
- addr_err  out  1  registered; last accepted request was outside the window.
- init_done  out  1  high once the array is usable.
- parity_err  out  1  registered; present only with INST_SRAM_PARITY_EN.

## Operation
- States: INIT, READY. Reset → INIT if CLEAR_ON_RESET else READY.
- Reset values: inst_sram_rdata 0, addr_err 0, parity_err 0, init_done 0 (1 when CLEAR_ON_RESET=0), sweep counter 0.
- INIT: one word per cycle, counter 0..2^ADDR_W-1 writes data 0 (and parity 0). After writing the last index → READY; init_done rises the same edge. All port requests ignored in INIT; rdata/addr_err hold.
- Decode: hit = addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]; idx = addr[ADDR_W+1:2]; addr[1:0] ignored (misalignment is flagged by the fetch stage, not here).
- READY, en=1, wen=0, hit: rdata ← mem[idx], addr_err ← 0.
- READY, en=1, wen≠0, hit: write enabled bytes of wdata to mem[idx]; rdata holds; addr_err ← 0.
- READY, en=1, miss: no array access; read → rdata ← 0; write dropped; addr_err ← 1.
- READY, en=0: rdata, addr_err, parity_err all hold.
- Back-to-back write then read of same idx: read returns new data (write committed first edge).
- Reset mid-sweep or mid-traffic: counter restarts at 0, state re-entered per CLEAR_ON_RESET.

## Timing
- Read latency exactly 1: request at edge N sampled, rdata valid after edge N, stable until next accepted read.
- Throughput one request per cycle, no backpressure.
- Init sweep: 2^ADDR_W cycles from first edge with reset low; init_done high after edge 2^ADDR_W.
- Fetch stage issues en=0 during reset, so first fetch (0xbfc0_0000) is served the cycle reset drops when CLEAR_ON_RESET=0.

## Configuration
- INST_SRAM_PARITY_EN defined: per-byte even-parity bit stored alongside each byte, written with its byte enable; on in-range read, parity_err ← OR of per-byte mismatches, registered with rdata; miss or write → parity_err ← 0.
- Undefined: no parity storage, no parity_err port, no checker logic.

## Structure
- Shared package inst_sram_pkg: state enum (INIT, READY), default BASE_ADDR constant 32'hbfc0_0000, exception vector constant 32'hbfc0_0380 shared with core.
- Sub-module inst_sram_array: synchronous single-port storage with 4 byte enables (plus parity lanes under macro); responder owns decode, FSM, sweep counter, output registers.

## Test plan
- CLEAR_ON_RESET=1, ADDR_W=4: reset 3 cycles → init_done low for 16 cycles, rises after 16th edge; read 0xbfc0_0008 → rdata 0, addr_err 0.
- Write 0xbfc0_0004 wen 4'b1111 data 0x1234_5678, then wen 4'b0010 data 0x0000_AB00, read → rdata 0x1234_AB78 one cycle after request.
- Read 0xbfc0_0000 returning 0xDEAD_BEEF, then en=0 for 5 cycles → rdata stays 0xDEAD_BEEF throughout.
- Read 0x0000_0000 (miss) → rdata 0, addr_err 1; next in-range read → addr_err 0; miss write leaves array unchanged.
- Assert reset at sweep index 7 → counter restarts, init_done low, full 16-cycle sweep repeats.
- INST_SRAM_PARITY_EN: write 0xFF00_FF00 at idx 2, flip stored parity bit of byte 1 hierarchically, read → parity_err 1 with rdata 0xFF00_FF00; clean word read → parity_err 0.
